// File: rtl/haar_stage_evaluator_if.sv
// Controller/ROM-facing bundle of the Haar stage evaluator.
// master drives stage requests, window and ROM data; slave is the evaluator.
interface haar_stage_evaluator_if #(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned PARAM_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH    = 12,
  parameter int unsigned WINDOW_PIXELS = 576,
  parameter int unsigned CNT_WIDTH     = 8,
  parameter int unsigned ACC_WIDTH     = 24
);
  logic                                i_start;
  logic [ADDR_WIDTH-1:0]               i_base_address;
  logic [CNT_WIDTH-1:0]                i_classifier_count;
  logic [ACC_WIDTH-1:0]                i_stage_threshold;
  logic [WINDOW_PIXELS*DATA_WIDTH-1:0] i_integral_window;
  logic [ADDR_WIDTH-1:0]               o_rom_address;
  logic [PARAM_WIDTH-1:0]              i_rom_q;
  logic                                o_busy;
  logic                                o_done;
  logic                                o_is_candidate;
  logic [ACC_WIDTH-1:0]                o_stage_sum;

  modport master (
    output i_start, i_base_address, i_classifier_count, i_stage_threshold,
           i_integral_window, i_rom_q,
    input  o_rom_address, o_busy, o_done, o_is_candidate, o_stage_sum
  );

  modport slave (
    input  i_start, i_base_address, i_classifier_count, i_stage_threshold,
           i_integral_window, i_rom_q,
    output o_rom_address, o_busy, o_done, o_is_candidate, o_stage_sum
  );
endinterface

// File: rtl/haar_stage_evaluator.sv
// Evaluates one Haar cascade stage: fetches classifier words from the stage ROM,
// sums weighted rectangles, accumulates left/right words. HAAR_STAGE_SAT_EN saturates the accumulator.
module haar_stage_evaluator #(
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned PARAM_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH    = 12,
  parameter int unsigned WINDOW_PIXELS = 576,
  parameter int unsigned INDEX_WIDTH   = 10,
  parameter int unsigned NUM_RECT      = 3,
  parameter int unsigned CNT_WIDTH     = 8,
  parameter int unsigned ACC_WIDTH     = 24
) (
  input  logic                   clk_fpga,
  input  logic                   reset_fpga,
  haar_stage_evaluator_if.slave  bus
);
  localparam int unsigned P      = 5 * NUM_RECT + 3;
  localparam int unsigned K_W    = $clog2(P + 1);
  localparam int unsigned TERM_W = DATA_WIDTH + 2;
  localparam int unsigned WIN_W  = WINDOW_PIXELS * DATA_WIDTH;
  localparam int unsigned OFF_W  = $clog2(WIN_W);
  localparam int unsigned WIDE_W = ((ACC_WIDTH > PARAM_WIDTH) ? ACC_WIDTH : PARAM_WIDTH) + 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LAST, S_EVAL, S_ACCUM, S_FINISH} state_t;

  state_t                        state_q, state_d;
  logic [K_W-1:0]                k_q, k_d;
  logic [CNT_WIDTH-1:0]          cls_q, cls_d, count_q, count_d;
  logic [ADDR_WIDTH-1:0]         addr_q, addr_d;
  logic signed [ACC_WIDTH-1:0]   thr_q, thr_d, acc_q, acc_d, feature_q, feature_d, sum_q, sum_d;
  logic                          busy_q, busy_d, done_q, done_d, cand_q, cand_d;
  logic                          cap_c;
  logic signed [ACC_WIDTH-1:0]   add_c;
  logic [PARAM_WIDTH-1:0]        params_q [P];
  logic signed [ACC_WIDTH-1:0]   psum [NUM_RECT+1];

  // Window sample lookup; corners outside the window read as zero.
  function automatic logic [DATA_WIDTH-1:0] sample(input logic [WIN_W-1:0] win,
                                                   input logic [PARAM_WIDTH-1:0] idx);
    logic [OFF_W-1:0] off;
    off = OFF_W'(idx[INDEX_WIDTH-1:0]) * OFF_W'(DATA_WIDTH);
    if (idx >= PARAM_WIDTH'(WINDOW_PIXELS)) sample = '0;
    else                                    sample = win[off +: DATA_WIDTH];
  endfunction

  for (genvar j = 0; j < P; j++) begin : g_param
    always_ff @(posedge clk_fpga) begin
      if (reset_fpga)                         params_q[j] <= '0;
      else if (cap_c && k_q == K_W'(j + 1))   params_q[j] <= bus.i_rom_q;
    end
  end

  assign psum[0] = '0;
  for (genvar r = 0; r < NUM_RECT; r++) begin : g_rect
    logic signed [TERM_W-1:0] term;
    assign term = $signed({2'b00, sample(bus.i_integral_window, params_q[5*r])})
                - $signed({2'b00, sample(bus.i_integral_window, params_q[5*r+1])})
                - $signed({2'b00, sample(bus.i_integral_window, params_q[5*r+2])})
                + $signed({2'b00, sample(bus.i_integral_window, params_q[5*r+3])});
    assign psum[r+1] = psum[r] + ACC_WIDTH'(term) * ACC_WIDTH'($signed(params_q[5*r+4]));
  end

  // Leaf selection and accumulator update, computed wide so saturation sees the true sum.
  always_comb begin : accum_add
    logic signed [WIDE_W-1:0] sum_w;
    logic [PARAM_WIDTH-1:0]   word;
    if (WIDE_W'(feature_q) < WIDE_W'($signed(params_q[5*NUM_RECT]))) word = params_q[P-2];
    else                                                               word = params_q[P-1];
    sum_w = WIDE_W'(acc_q) + WIDE_W'($signed(word));
`ifdef HAAR_STAGE_SAT_EN
    if (sum_w > $signed({{(WIDE_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}}))
      add_c = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    else if (sum_w < $signed({{(WIDE_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}}))
      add_c = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else
      add_c = ACC_WIDTH'(sum_w);
`else
    add_c = ACC_WIDTH'(sum_w);
`endif
  end

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.i_start) state_d = (bus.i_classifier_count == '0) ? S_FINISH : S_FETCH;
      S_FETCH:  if (k_q == K_W'(P - 1)) state_d = S_LAST;
      S_LAST:   state_d = S_EVAL;
      S_EVAL:   state_d = S_ACCUM;
      S_ACCUM:  state_d = (cls_q + CNT_WIDTH'(1) == count_q) ? S_FINISH : S_FETCH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin : output_next
    addr_d = addr_q;  k_d = k_q;  cls_d = cls_q;  count_d = count_q;
    thr_d = thr_q;  acc_d = acc_q;  feature_d = feature_q;
    cand_d = cand_q;  sum_d = sum_q;  cap_c = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.i_start) begin
        count_d = bus.i_classifier_count;
        thr_d   = bus.i_stage_threshold;
        acc_d   = '0;  cls_d = '0;  k_d = '0;  cand_d = 1'b0;  sum_d = '0;
        if (bus.i_classifier_count != '0) addr_d = bus.i_base_address;
      end
      S_FETCH: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        k_d    = k_q + K_W'(1);
        cap_c  = (k_q != '0);
      end
      S_LAST:  cap_c = 1'b1;
      S_EVAL:  feature_d = psum[NUM_RECT];
      S_ACCUM: begin
        acc_d = add_c;
        cls_d = cls_q + CNT_WIDTH'(1);
        k_d   = '0;
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
    if (state_d == S_FINISH) begin
      cand_d = (acc_d >= thr_d);
      sum_d  = acc_d;
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      addr_q <= '0;  k_q <= '0;  cls_q <= '0;  count_q <= '0;
      thr_q <= '0;  acc_q <= '0;  feature_q <= '0;
      busy_q <= 1'b0;  done_q <= 1'b0;  cand_q <= 1'b0;  sum_q <= '0;
    end else begin
      addr_q <= addr_d;  k_q <= k_d;  cls_q <= cls_d;  count_q <= count_d;
      thr_q <= thr_d;  acc_q <= acc_d;  feature_q <= feature_d;
      busy_q <= busy_d;  done_q <= done_d;  cand_q <= cand_d;  sum_q <= sum_d;
    end
  end

  assign bus.o_rom_address  = addr_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_done         = done_q;
  assign bus.o_is_candidate = cand_q;
  assign bus.o_stage_sum    = sum_q;
endmodule

// File: tb/tb_haar_stage_evaluator.sv
// Randomized and directed checks of haar_stage_evaluator against an arithmetic stage model.
// A second instance with an 8-bit accumulator exercises overflow behaviour.
module tb_haar_stage_evaluator;
  localparam int unsigned AW = 10, PW = 16, DW = 12, WP = 576, IW = 10, NR = 3, CW = 8;
  localparam int unsigned ACCW = 24, ACC8 = 8;
  localparam int P = 5 * NR + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  haar_stage_evaluator_if #(.ADDR_WIDTH(AW), .PARAM_WIDTH(PW), .DATA_WIDTH(DW),
    .WINDOW_PIXELS(WP), .CNT_WIDTH(CW), .ACC_WIDTH(ACCW)) bus();
  haar_stage_evaluator_if #(.ADDR_WIDTH(AW), .PARAM_WIDTH(PW), .DATA_WIDTH(DW),
    .WINDOW_PIXELS(WP), .CNT_WIDTH(CW), .ACC_WIDTH(ACC8)) bus8();

  haar_stage_evaluator #(.ADDR_WIDTH(AW), .PARAM_WIDTH(PW), .DATA_WIDTH(DW),
    .WINDOW_PIXELS(WP), .INDEX_WIDTH(IW), .NUM_RECT(NR), .CNT_WIDTH(CW), .ACC_WIDTH(ACCW))
    u_dut (.clk_fpga(clk), .reset_fpga(rst), .bus(bus));
  haar_stage_evaluator #(.ADDR_WIDTH(AW), .PARAM_WIDTH(PW), .DATA_WIDTH(DW),
    .WINDOW_PIXELS(WP), .INDEX_WIDTH(IW), .NUM_RECT(NR), .CNT_WIDTH(CW), .ACC_WIDTH(ACC8))
    u_dut8 (.clk_fpga(clk), .reset_fpga(rst), .bus(bus8));

  logic [PW-1:0] rom [1024];
  int            win_a [WP];
  int            total = 0;
  int            bad = 0;

  // Synchronous stage ROM, one cycle read latency.
  always @(posedge clk) begin
    bus.i_rom_q  <= rom[bus.o_rom_address];
    bus8.i_rom_q <= rom[bus8.o_rom_address];
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrapw(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic longint satw(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic int ru(input int a);
    return int'(rom[AW'(a % 1024)]);
  endfunction

  function automatic longint rs(input int a);
    return longint'($signed(rom[AW'(a % 1024)]));
  endfunction

  function automatic longint smp(input int idx);
    return (idx < WP) ? longint'(win_a[idx]) : 0;
  endfunction

  task automatic put(input int a, input int v);
    rom[AW'(a % 1024)] = PW'(v);
  endtask

  task automatic pack_win();
    logic [WP*DW-1:0] w;
    w = '0;
    for (int k = 0; k < WP; k++) w = {DW'(win_a[k]), w[WP*DW-1:DW]};
    bus.i_integral_window  = w;
    bus8.i_integral_window = w;
  endtask

  // Stage result straight from the classifier arithmetic.
  task automatic model(input int base, input int count, input longint sthr, input int accw,
                       output longint esum, output bit ecand);
    longint acc, feat, thr, word;
    int a0;
    acc = 0;
    for (int c = 0; c < count; c++) begin
      a0 = base + c * P;
      feat = 0;
      for (int r = 0; r < NR; r++)
        feat += (smp(ru(a0+5*r)) - smp(ru(a0+5*r+1)) - smp(ru(a0+5*r+2)) + smp(ru(a0+5*r+3)))
                * rs(a0+5*r+4);
      feat = wrapw(feat, accw);
      thr  = rs(a0 + 5 * NR);
      word = (feat < thr) ? rs(a0 + P - 2) : rs(a0 + P - 1);
`ifdef HAAR_STAGE_SAT_EN
      acc = satw(acc + word, accw);
`else
      acc = wrapw(acc + word, accw);
`endif
    end
    esum  = acc;
    ecand = (acc >= wrapw(sthr, accw));
  endtask

  task automatic set_in(input int sel, input bit st, input int base, input int count,
                        input longint sthr);
    if (sel == 0) begin
      bus.i_start = st;  bus.i_base_address = AW'(base);
      bus.i_classifier_count = CW'(count);  bus.i_stage_threshold = ACCW'(sthr);
    end else begin
      bus8.i_start = st;  bus8.i_base_address = AW'(base);
      bus8.i_classifier_count = CW'(count);  bus8.i_stage_threshold = ACC8'(sthr);
    end
  endtask

  function automatic bit o_done(input int sel);
    return (sel == 0) ? bus.o_done : bus8.o_done;
  endfunction
  function automatic bit o_busy(input int sel);
    return (sel == 0) ? bus.o_busy : bus8.o_busy;
  endfunction
  function automatic bit o_cand(input int sel);
    return (sel == 0) ? bus.o_is_candidate : bus8.o_is_candidate;
  endfunction
  function automatic longint o_sum(input int sel);
    return (sel == 0) ? longint'($signed(bus.o_stage_sum)) : longint'($signed(bus8.o_stage_sum));
  endfunction
  function automatic int o_addr(input int sel);
    return (sel == 0) ? int'(bus.o_rom_address) : int'(bus8.o_rom_address);
  endfunction

  task automatic fill_rand(input int base, input int count);
    for (int c = 0; c < count; c++) begin
      for (int r = 0; r < NR; r++) begin
        for (int j = 0; j < 4; j++) put(base + c*P + 5*r + j, int'($urandom_range(0, 700)));
        put(base + c*P + 5*r + 4, int'($urandom_range(0, 6)) - 3);
      end
      put(base + c*P + 5*NR,     int'($urandom_range(0, 16000)) - 8000);
      put(base + c*P + 5*NR + 1, int'($urandom_range(0, 2000)) - 1000);
      put(base + c*P + 5*NR + 2, int'($urandom_range(0, 2000)) - 1000);
    end
  endtask

  // One stage: start, follow the ROM address stream, check timing and result.
  task automatic run_stage(input int sel, input int base, input int count, input longint sthr,
                           input int glitch_cyc, input bit start_at_done);
    longint esum;
    bit     ecand;
    int     edone, cyc, addr0, c, k;
    model(base, count, sthr, (sel == 0) ? ACCW : ACC8, esum, ecand);
    edone = count * (P + 3) + 1;
    @(negedge clk);
    addr0 = o_addr(sel);
    set_in(sel, 1'b1, base, count, sthr);
    @(negedge clk);
    set_in(sel, 1'b0, base, count, sthr);
    cyc = 1;
    chk("busy_on", o_busy(sel), 1);
    while (!o_done(sel) && cyc < edone + 20) begin
      c = (cyc - 1) / (P + 3);
      k = (cyc - 1) % (P + 3);
      if (c < count && k < P) chk("rom_addr", o_addr(sel), (base + c * P + k) % 1024);
      if (cyc == glitch_cyc) set_in(sel, 1'b1, base ^ 'h155, count + 1, -sthr);
      else                   set_in(sel, 1'b0, base, count, sthr);
      @(negedge clk);
      cyc++;
    end
    set_in(sel, 1'b0, base, count, sthr);
    chk("done_cycle", cyc, edone);
    chk("stage_sum", o_sum(sel), esum);
    chk("candidate", o_cand(sel), ecand);
    chk("busy_at_done", o_busy(sel), 1);
    if (count == 0) chk("addr_hold", o_addr(sel), addr0);
    if (start_at_done) set_in(sel, 1'b1, base, count, sthr);
    @(negedge clk);
    set_in(sel, 1'b0, base, count, sthr);
    chk("done_pulse", o_done(sel), 0);
    chk("busy_off", o_busy(sel), 0);
    @(negedge clk);
    chk("stay_idle", o_busy(sel), 0);
    chk("sum_held", o_sum(sel), esum);
  endtask

  initial begin
    int  cyc;
    bit  seen;
    for (int a = 0; a < 1024; a++) rom[a] = '0;
    for (int k = 0; k < WP; k++) win_a[k] = k;
    pack_win();
    set_in(0, 1'b0, 0, 0, 0);
    set_in(1, 1'b0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_cand", bus.o_is_candidate, 0);
    chk("rst_sum", o_sum(0), 0);
    chk("rst_addr", o_addr(0), 0);
    rst = 1'b0;

    // Single classifier: feature 30-20-10+0 = 0 < 5 picks left word -3.
    put(0, 30); put(1, 20); put(2, 10); put(3, 0); put(4, 1);
    put(15, 5); put(16, -3); put(17, 7);
    run_stage(0, 0, 1, 7, 0, 1'b0);
    chk("t1_sum_const", o_sum(0), -3);
    run_stage(0, 0, 1, -3, 0, 1'b1);
    chk("t2_cand_const", o_cand(0), 1);

    fill_rand(1020, 3);
    run_stage(0, 1020, 3, 0, 0, 1'b0);
    run_stage(0, 5, 0, 0, 0, 1'b0);

    // Out-of-window corner next to the last valid sample.
    put(300, 600); put(301, 0); put(302, 0); put(303, 0); put(304, 1);
    put(305, 575); put(306, 0); put(307, 0); put(308, 0); put(309, 1);
    for (int j = 310; j < 315; j++) put(j, 0);
    put(315, 576); put(316, 11); put(317, 22);
    run_stage(0, 300, 1, 0, 0, 1'b0);
    chk("t5_sum_const", o_sum(0), 11);

    run_stage(0, 1020, 3, 5, 15, 1'b1);

    // Mid-stage reset aborts without a done pulse.
    @(negedge clk);
    set_in(0, 1'b1, 1020, 3, 0);
    @(negedge clk);
    set_in(0, 1'b0, 1020, 3, 0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", bus.o_busy, 0);
    chk("mid_rst_done", bus.o_done, 0);
    chk("mid_rst_cand", bus.o_is_candidate, 0);
    chk("mid_rst_sum", o_sum(0), 0);
    chk("mid_rst_addr", o_addr(0), 0);
    seen = 1'b0;
    for (cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (bus.o_done) seen = 1'b1;
    end
    chk("mid_rst_no_done", seen, 0);
    run_stage(0, 1020, 3, 0, 0, 1'b0);

    // Four right words of 100 into an 8-bit accumulator.
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 5 * NR; j++) put(200 + c*P + j, 0);
      put(200 + c*P + 5*NR, -1);
      put(200 + c*P + 5*NR + 1, -50);
      put(200 + c*P + 5*NR + 2, 100);
    end
    run_stage(1, 200, 4, 0, 0, 1'b0);
`ifdef HAAR_STAGE_SAT_EN
    chk("ovf_sum_const", o_sum(1), 127);
`else
    chk("ovf_sum_const", o_sum(1), -112);
`endif

    for (int t = 0; t < 14; t++) begin
      int base, count;
      for (int k = 0; k < WP; k++) win_a[k] = int'($urandom_range(0, 4095));
      pack_win();
      base  = int'($urandom_range(0, 1023));
      count = int'($urandom_range(1, 4));
      fill_rand(base, count);
      run_stage(0, base, count, longint'(int'($urandom_range(0, 6000)) - 3000), 0,
                t[0] == 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
